// File: rtl/ras_ctrl.sv
// ras_ctrl: front-end sequencer for the return-address stack.
// Turns fetch call/return requests into RAS push/pop, builds the per-stage
// commit/flush vectors, and tracks speculative occupancy with per-stage
// snapshots so a kill can restore the count in one cycle.
module ras_ctrl #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 31,
   parameter int DEPTH  = 1024,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_call,
   input  logic              req_ret,
   input  logic [WIDTH-1:0]  req_addr,
   input  logic [STAGES-1:0] adv_i,
   input  logic [STAGES-1:0] kill_i,
   output logic              push,
   output logic              pop,
   output logic [WIDTH-1:0]  din,
   output logic [STAGES-1:0] commit,
   output logic [STAGES-1:0] flush,
   output logic [CW-1:0]     count,
   output logic              underflow,
   output logic              overflow
);

   localparam logic [0:0]    IDLE    = 1'b0;
   localparam logic [0:0]    RECOVER = 1'b1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);

   logic [0:0]        state;
   logic [CW-1:0]     occ;
   logic [CW-1:0]     occ_nxt;
   logic [CW-1:0]     snap [STAGES];
   logic [CW-1:0]     kill_snap;
   logic [STAGES-1:0] flush_therm;
   logic              kill_any;
   logic              fire;
   logic              call_only;
   logic              ret_only;
   logic              is_empty;
   logic              is_full;
   logic              thru;

   // Kill decode: oldest killed stage selects the restore snapshot and
   // the flush vector covers it and every younger stage.
   always_comb begin
      kill_snap   = '0;
      flush_therm = '0;
      thru        = 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         if (kill_i[i]) kill_snap = snap[i];
      end
      for (int unsigned i = 0; i < STAGES; i++) begin
         thru = thru | kill_i[STAGES-1-i];
         flush_therm[STAGES-1-i] = thru;
      end
   end

   // Request handshake, RAS controls, pulses and next occupancy.
   always_comb begin
      kill_any  = !rst_i && (state == IDLE) && (kill_i != '0);
      req_ready = !rst_i && (state == IDLE) && !kill_any;
      fire      = req_valid && req_ready;
      call_only = req_call && !req_ret;
      ret_only  = req_ret && !req_call;
      is_empty  = (occ == '0);
      is_full   = (occ == FULL);

      push      = fire && req_call;
      pop       = fire && req_ret && !(ret_only && is_empty);
      underflow = fire && ret_only && is_empty;
      overflow  = fire && call_only && is_full;
      din       = rst_i ? '0 : req_addr;
      commit    = (!rst_i && (state == IDLE) && !kill_any) ? adv_i : '0;
      flush     = kill_any ? flush_therm : '0;
      count     = rst_i ? '0 : occ;

      occ_nxt = occ;
      if (kill_any) begin
         occ_nxt = kill_snap;
      end else if (fire) begin
         if (call_only && !is_full) occ_nxt = occ + 1'b1;
         else if (ret_only && !is_empty) occ_nxt = occ - 1'b1;
      end
   end

   // State, occupancy and snapshot registers; snapshots shift on commit
   // using pre-cycle values so simultaneous commits pass data one stage.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state <= IDLE;
         occ   <= '0;
         for (int unsigned i = 0; i < STAGES; i++) snap[i] <= '0;
      end else begin
         state <= kill_any ? RECOVER : IDLE;
         occ   <= occ_nxt;
         if (commit[0]) snap[0] <= occ;
         for (int unsigned i = 1; i < STAGES; i++) begin
            if (commit[i]) snap[i] <= snap[i-1];
         end
      end
   end

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: scoreboard bench for ras_ctrl. Two instances share the
// stimulus: the default-depth one and a DEPTH=4 one for saturation.
module tb_ras_ctrl;

   typedef struct {
      logic        rdy, psh, pp;
      logic [30:0] din;
      logic [1:0]  cm, fl;
      logic        uf, of;
      logic [10:0] cnt;
      logic        sm;
      logic [2:0]  scnt;
      logic        sof;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i, req_valid, req_call, req_ret;
   logic [30:0] req_addr;
   logic [1:0]  adv_i, kill_i;

   logic        req_ready, push, pop, underflow, overflow;
   logic [30:0] din;
   logic [1:0]  commit, flush;
   logic [10:0] count;

   logic        s_ready, s_push, s_pop, s_under, s_over;
   logic [30:0] s_din;
   logic [1:0]  s_commit, s_flush;
   logic [2:0]  s_count;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   localparam logic [30:0] A = 31'h1234_5678;
   localparam logic [30:0] B = 31'h0bad_cafe;
   localparam logic [30:0] C = 31'h7fff_0001;

   always #5 clk = ~clk;

   ras_ctrl u_dut (
      .clk(clk), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready),
      .req_call(req_call), .req_ret(req_ret), .req_addr(req_addr),
      .adv_i(adv_i), .kill_i(kill_i), .push(push), .pop(pop), .din(din),
      .commit(commit), .flush(flush), .count(count),
      .underflow(underflow), .overflow(overflow)
   );

   ras_ctrl #(.STAGES(2), .WIDTH(31), .DEPTH(4)) u_small (
      .clk(clk), .rst_i(rst_i), .req_valid(req_valid), .req_ready(s_ready),
      .req_call(req_call), .req_ret(req_ret), .req_addr(req_addr),
      .adv_i(adv_i), .kill_i(kill_i), .push(s_push), .pop(s_pop), .din(s_din),
      .commit(s_commit), .flush(s_flush), .count(s_count),
      .underflow(s_under), .overflow(s_over)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic drv(input logic r, input logic v, input logic c, input logic rt,
                      input logic [30:0] a, input logic [1:0] adv, input logic [1:0] kl);
      rst_i = r; req_valid = v; req_call = c; req_ret = rt;
      req_addr = a; adv_i = adv; kill_i = kl;
   endtask

   task automatic ex(input logic rdy, input logic psh, input logic pp, input logic [30:0] d,
                     input logic [1:0] cm, input logic [1:0] fl, input logic uf,
                     input logic of, input logic [10:0] cnt, input logic sm = 1'b0,
                     input logic [2:0] scnt = 3'd0, input logic sof = 1'b0);
      exp_t e;
      e.rdy = rdy; e.psh = psh; e.pp = pp; e.din = d; e.cm = cm; e.fl = fl;
      e.uf = uf; e.of = of; e.cnt = cnt; e.sm = sm; e.scnt = scnt; e.sof = sof;
      sb.push_back(e);
   endtask

   // Sample on the falling edge, compare against the oldest expectation,
   // then step past the next rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("req_ready", 32'(req_ready), 32'(e.rdy));
         chk("push", 32'(push), 32'(e.psh));
         chk("pop", 32'(pop), 32'(e.pp));
         chk("din", 32'(din), 32'(e.din));
         chk("commit", 32'(commit), 32'(e.cm));
         chk("flush", 32'(flush), 32'(e.fl));
         chk("underflow", 32'(underflow), 32'(e.uf));
         chk("overflow", 32'(overflow), 32'(e.of));
         chk("count", 32'(count), 32'(e.cnt));
         if (e.sm) begin
            chk("small_count", 32'(s_count), 32'(e.scnt));
            chk("small_overflow", 32'(s_over), 32'(e.sof));
            chk("small_push", 32'(s_push), 32'(e.psh));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drv(1, 1, 1, 1, A, 2'b11, 2'b11);
      ex(0, 0, 0, 31'd0, 2'b00, 2'b00, 0, 0, 11'd0, 1, 3'd0, 0);
      tick();
   endtask

   initial begin
      drv(1, 0, 0, 0, 31'd0, 2'b00, 2'b00);
      @(posedge clk);
      #1;

      // Reset dominates every other input.
      do_reset();

      // Three calls.
      drv(0, 1, 1, 0, A, 2'b00, 2'b00); ex(1, 1, 0, A, 0, 0, 0, 0, 11'd0); tick();
      drv(0, 1, 1, 0, B, 2'b00, 2'b00); ex(1, 1, 0, B, 0, 0, 0, 0, 11'd1); tick();
      drv(0, 1, 1, 0, C, 2'b00, 2'b00); ex(1, 1, 0, C, 0, 0, 0, 0, 11'd2); tick();
      drv(0, 0, 0, 0, C, 2'b00, 2'b00); ex(1, 0, 0, C, 0, 0, 0, 0, 11'd3); tick();

      // Return on empty stack.
      do_reset();
      drv(0, 1, 0, 1, B, 2'b00, 2'b00); ex(1, 0, 0, B, 0, 0, 1, 0, 11'd0); tick();
      drv(0, 0, 0, 0, B, 2'b00, 2'b00); ex(1, 0, 0, B, 0, 0, 0, 0, 11'd0); tick();

      // Calls, commit stage 0, one more call, kill stage 0, recovery.
      drv(0, 1, 1, 0, A, 2'b00, 2'b00); ex(1, 1, 0, A, 0, 0, 0, 0, 11'd0); tick();
      drv(0, 1, 1, 0, B, 2'b00, 2'b00); ex(1, 1, 0, B, 0, 0, 0, 0, 11'd1); tick();
      drv(0, 0, 0, 0, B, 2'b01, 2'b00); ex(1, 0, 0, B, 2'b01, 0, 0, 0, 11'd2); tick();
      drv(0, 1, 1, 0, C, 2'b00, 2'b00); ex(1, 1, 0, C, 0, 0, 0, 0, 11'd2); tick();
      drv(0, 1, 1, 0, A, 2'b00, 2'b01); ex(0, 0, 0, A, 0, 2'b01, 0, 0, 11'd3); tick();
      drv(0, 1, 1, 0, A, 2'b11, 2'b10); ex(0, 0, 0, A, 0, 2'b00, 0, 0, 11'd2); tick();
      drv(0, 0, 0, 0, A, 2'b00, 2'b00); ex(1, 0, 0, A, 0, 0, 0, 0, 11'd2); tick();

      // Five calls: saturation on DEPTH=4, then call+ret at count 5.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drv(0, 1, 1, 0, A + 31'(i), 2'b00, 2'b00);
         ex(1, 1, 0, A + 31'(i), 0, 0, 0, 0, 11'(i), 1, (i < 4) ? 3'(i) : 3'd4, i == 4);
         tick();
      end
      drv(0, 1, 1, 1, C, 2'b00, 2'b00); ex(1, 1, 1, C, 0, 0, 0, 0, 11'd5, 1, 3'd4, 0); tick();
      drv(0, 0, 0, 0, C, 2'b00, 2'b00); ex(1, 0, 0, C, 0, 0, 0, 0, 11'd5, 1, 3'd4, 0); tick();

      // Kill stage 1 alongside advance and a request: restore from snap[1].
      do_reset();
      drv(0, 1, 1, 0, A, 2'b00, 2'b00); ex(1, 1, 0, A, 0, 0, 0, 0, 11'd0); tick();
      drv(0, 1, 1, 0, B, 2'b00, 2'b00); ex(1, 1, 0, B, 0, 0, 0, 0, 11'd1); tick();
      drv(0, 0, 0, 0, B, 2'b01, 2'b00); ex(1, 0, 0, B, 2'b01, 0, 0, 0, 11'd2); tick();
      drv(0, 0, 0, 0, B, 2'b10, 2'b00); ex(1, 0, 0, B, 2'b10, 0, 0, 0, 11'd2); tick();
      drv(0, 1, 1, 0, C, 2'b00, 2'b00); ex(1, 1, 0, C, 0, 0, 0, 0, 11'd2); tick();
      drv(0, 1, 1, 0, A, 2'b00, 2'b00); ex(1, 1, 0, A, 0, 0, 0, 0, 11'd3); tick();
      drv(0, 1, 1, 0, B, 2'b11, 2'b10); ex(0, 0, 0, B, 2'b00, 2'b11, 0, 0, 11'd4); tick();
      drv(0, 0, 0, 0, B, 2'b00, 2'b00); ex(0, 0, 0, B, 0, 0, 0, 0, 11'd2); tick();
      drv(0, 0, 0, 0, B, 2'b00, 2'b00); ex(1, 0, 0, B, 0, 0, 0, 0, 11'd2); tick();

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
